// File: rtl/hex_display_mux_pkg.sv
// Shared definitions for the multiplexed hex display: glyph table,
// sequencer states and the all-segments-off pattern.
package hex_disp_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } disp_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low g..a patterns, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_display_mux_glyph_lut.sv
// Nibble to active-low seven-segment glyph lookup.
module hex_glyph_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Pure table lookup; every nibble value has an entry.
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver with frame-synchronous data commit,
// leading-zero blanking and anti-ghosting gap cycles between digits.
module hex_display_mux
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  disp_state_e             state_r, state_nx_s;
  logic [IDX_W-1:0]        idx_r, idx_nx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
  logic                    run_r;
  logic                    slot_end_s, frame_end_s, fd_nx_s;

  logic [4*NUM_DIGITS-1:0] act_val_r, pend_val_r, act_val_nx_s;
  logic [NUM_DIGITS-1:0]   act_dp_r, pend_dp_r, act_dp_nx_s;
  logic                    act_blank_r, pend_blank_r, act_blank_nx_s;
  logic                    pend_valid_r;

  logic [NUM_DIGITS-1:0]   blank_mask_s;
  logic [3:0]              nibble_s;
  logic [6:0]              glyph_s;

  // Advance the SHOW/GAP sequencer; run_r holds the first post-reset cycle on digit 0.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    cnt_nx_s   = cnt_r;
    slot_end_s = 1'b0;
    if (!run_r) begin
      state_nx_s = SHOW;
      idx_nx_s   = '0;
      cnt_nx_s   = '0;
    end else begin
      case (state_r)
        SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            cnt_nx_s = '0;
            if (GAP_CYCLES > 0) begin
              state_nx_s = GAP;
            end else begin
              slot_end_s = 1'b1;
            end
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_nx_s   = '0;
            state_nx_s = SHOW;
            slot_end_s = 1'b1;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx_s = SHOW;
          cnt_nx_s   = '0;
        end
      endcase
      if (slot_end_s) begin
        idx_nx_s = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_ONE;
      end else begin
        idx_nx_s = idx_r;
      end
    end
  end

  assign frame_end_s = run_r && slot_end_s && (idx_r == IDX_LAST);

  // Flag whether the upcoming cycle is the last one of a frame.
  always_comb begin
    if (GAP_CYCLES > 0) begin
      fd_nx_s = (state_nx_s == GAP) && (cnt_nx_s == GAP_LAST) && (idx_nx_s == IDX_LAST);
    end else begin
      fd_nx_s = (state_nx_s == SHOW) && (cnt_nx_s == SHOW_LAST) && (idx_nx_s == IDX_LAST);
    end
  end

  // Data shown from the next cycle on: only a frame boundary may change it.
  always_comb begin
    if (frame_end_s && load) begin
      act_val_nx_s   = value;
      act_dp_nx_s    = dp_in;
      act_blank_nx_s = blank_lz;
    end else if (frame_end_s && pend_valid_r) begin
      act_val_nx_s   = pend_val_r;
      act_dp_nx_s    = pend_dp_r;
      act_blank_nx_s = pend_blank_r;
    end else begin
      act_val_nx_s   = act_val_r;
      act_dp_nx_s    = act_dp_r;
      act_blank_nx_s = act_blank_r;
    end
  end

  // A digit above 0 is blanked when it and every higher nibble are zero.
  always_comb begin
    blank_mask_s = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank_mask_s[i] = act_blank_nx_s && ((act_val_nx_s >> (4 * i)) == '0);
    end
  end

  assign nibble_s = 4'(act_val_nx_s >> {idx_nx_s, 2'b00});

  hex_glyph_lut u_glyph (
    .nibble (nibble_s),
    .glyph  (glyph_s)
  );

  // Sequencer, data registers and display outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r        <= 1'b0;
      state_r      <= SHOW;
      idx_r        <= '0;
      cnt_r        <= '0;
      act_val_r    <= '0;
      act_dp_r     <= '0;
      act_blank_r  <= 1'b0;
      pend_val_r   <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= 1'b0;
      pend_valid_r <= 1'b0;
      an           <= '1;
      seg          <= SEG_OFF;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      run_r       <= 1'b1;
      state_r     <= state_nx_s;
      idx_r       <= idx_nx_s;
      cnt_r       <= cnt_nx_s;
      act_val_r   <= act_val_nx_s;
      act_dp_r    <= act_dp_nx_s;
      act_blank_r <= act_blank_nx_s;
      if (frame_end_s) begin
        pend_valid_r <= 1'b0;
      end else if (load) begin
        pend_val_r   <= value;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_lz;
        pend_valid_r <= 1'b1;
      end
      frame_done <= fd_nx_s;
      if (state_nx_s == SHOW) begin
        an  <= ~(AN_ONE << idx_nx_s);
        seg <= blank_mask_s[idx_nx_s] ? SEG_OFF : glyph_s;
        dp  <= ~act_dp_nx_s[idx_nx_s];
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Randomized bench for hex_display_mux: two configurations run in lockstep
// against a frame-position reference model.
module tb_hex_display_mux;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] an_a, an_b;

  hex_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
  );

  hex_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per unit: position within the frame (-1 = held in reset).
  int          rd_m [2] = '{4, 1};
  int          gap_m[2] = '{1, 0};
  int          pos_m[2];
  logic [15:0] act_v[2], pend_v[2];
  logic [3:0]  act_d[2], pend_d[2];
  logic        act_b[2], pend_b[2], pend_ok[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check_unit(input int k, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp, input logic fd);
    int slot, d, off;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (pos_m[k] >= 0) begin
      slot = rd_m[k] + gap_m[k];
      d    = pos_m[k] / slot;
      off  = pos_m[k] % slot;
      e_fd = (pos_m[k] == ND * slot - 1);
      if (off < rd_m[k]) begin
        e_an = ~(4'b0001 << d);
        e_dp = ~act_d[k][d];
        if (act_b[k] && d > 0 && (act_v[k] >> (4 * d)) == 16'h0) e_seg = 7'h7F;
        else e_seg = ref_glyph(4'(act_v[k] >> (4 * d)));
      end
    end
    check_eq($sformatf("u%0d_an", k),  32'(an),  32'(e_an));
    check_eq($sformatf("u%0d_seg", k), 32'(seg), 32'(e_seg));
    check_eq($sformatf("u%0d_dp", k),  32'(dp),  32'(e_dp));
    check_eq($sformatf("u%0d_frame_done", k), 32'(fd), 32'(e_fd));
  endtask

  // Apply one clock edge to the model using the inputs sampled at that edge.
  task automatic step_unit(input int k);
    int len;
    len = ND * (rd_m[k] + gap_m[k]);
    if (reset) begin
      pos_m[k] = -1;
      act_v[k] = 16'h0; act_d[k] = 4'h0; act_b[k] = 1'b0;
      pend_v[k] = 16'h0; pend_d[k] = 4'h0; pend_b[k] = 1'b0; pend_ok[k] = 1'b0;
    end else begin
      if (pos_m[k] == len - 1) begin
        if (load) begin
          act_v[k] = value; act_d[k] = dp_in; act_b[k] = blank_lz;
        end else if (pend_ok[k]) begin
          act_v[k] = pend_v[k]; act_d[k] = pend_d[k]; act_b[k] = pend_b[k];
        end
        pend_ok[k] = 1'b0;
      end else if (load) begin
        pend_v[k] = value; pend_d[k] = dp_in; pend_b[k] = blank_lz; pend_ok[k] = 1'b1;
      end
      pos_m[k] = (pos_m[k] + 1) % len;
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic b);
    @(negedge clk);
    check_unit(0, an_a, seg_a, dp_a, fd_a);
    check_unit(1, an_b, seg_b, dp_b, fd_b);
    reset = r; load = l; value = v; dp_in = d; blank_lz = b;
    @(posedge clk);
    step_unit(0);
    step_unit(1);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 40 && pos_m[0] != p; i++) idle();
    check_eq("wait_pos", 32'(pos_m[0]), 32'(p));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    @(posedge clk);
    step_unit(0);
    step_unit(1);
    tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

    // Free-running frames with no data loaded.
    repeat (45) idle();

    // Mid-frame load appears only from the next frame.
    wait_pos(7);
    tick(1'b0, 1'b1, 16'hB8D1, 4'h0, 1'b0);
    repeat (45) idle();

    // Leading-zero blanking with a decimal point on a blanked digit.
    wait_pos(3);
    tick(1'b0, 1'b1, 16'h0070, 4'b1000, 1'b1);
    repeat (45) idle();

    // Last write wins; a load on the frame_done cycle commits directly.
    wait_pos(2);
    tick(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle();
    tick(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
    wait_pos(19);
    tick(1'b0, 1'b1, 16'h4444, 4'h0, 1'b0);
    repeat (45) idle();

    // Reset mid-frame discards pending data.
    wait_pos(5);
    tick(1'b0, 1'b1, 16'h5A5A, 4'hF, 1'b0);
    repeat (3) idle();
    tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (45) idle();

    // Randomized traffic including occasional resets and frame-edge loads.
    repeat (3000) begin
      tick(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom), 1'($urandom));
    end
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
